// File: rtl/idu_scoreboard.sv
// idu_scoreboard: decode->execute hazard controller.
//   Keeps a saturating pending-write counter per architectural register
//   (x0 is never tracked). It blocks the decode->execute handshake while a
//   source register has a write in flight (RAW). It also blocks while the
//   destination counter is full, so a counter can never wrap.
// Ports:
//   clk, rst            clock, async active-low reset
//   valid_pre_i/ready_pre_o    upstream (decode) handshake
//   valid_post_o/ready_post_i  downstream (execute) handshake
//   rena1_i/raddr1_i, rena2_i/raddr2_i  source reads of the decoded instr
//   wena_i/waddr_i      destination write of the decoded instr
//   retire_i/retire_addr_i     writeback commit
//   stall_o             hazard present this cycle (combinational)
//   busy_o              any counter non-zero
//   stall_cnt_o         count of cycles spent stalled with valid upstream

// One pending-write counter. Issue and retire in the same cycle cancel out.
// A decrement of an already-zero counter is held at zero.
module idu_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         cnt <= '0;
    else if (inc && !dec)             cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
  end
endmodule

module idu_scoreboard #(
  parameter int NR_REGS = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_pre_i,
  output logic              ready_pre_o,
  output logic              valid_post_o,
  input  logic              ready_post_i,
  input  logic              rena1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic              rena2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic              wena_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              retire_i,
  input  logic [ADDR_W-1:0] retire_addr_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic [31:0]       stall_cnt_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NR_REGS-1:0][CNT_W-1:0] cnt;
  logic [NR_REGS-1:0]            inc, dec;
  logic                          raw1, raw2, sat, issue;
  logic                          unused_x0;

  // Hazards look only at registered counts. A retire landing this cycle
  // releases its readers one cycle later, which keeps the path short.
  assign raw1 = rena1_i && (raddr1_i != '0) && (cnt[raddr1_i] != '0);
  assign raw2 = rena2_i && (raddr2_i != '0) && (cnt[raddr2_i] != '0);
  assign sat  = wena_i  && (waddr_i  != '0) && (cnt[waddr_i] == CNT_MAX);

  assign stall_o      = valid_pre_i && (raw1 || raw2 || sat);
  assign valid_post_o = valid_pre_i && !stall_o;
  assign ready_pre_o  = ready_post_i && !stall_o;
  assign issue        = valid_pre_i && ready_pre_o;
  assign busy_o       = |cnt;

  always_comb begin
    inc = '0;
    dec = '0;
    if (issue && wena_i && (waddr_i != '0)) inc[waddr_i]       = 1'b1;
    if (retire_i && (retire_addr_i != '0))  dec[retire_addr_i] = 1'b1;
  end

  // x0 is hardwired: its request bits are simply dropped.
  assign cnt[0]    = '0;
  assign unused_x0 = inc[0] ^ dec[0];

  for (genvar r = 1; r < NR_REGS; r++) begin : g_reg
    idu_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[r]),
      .dec (dec[r]),
      .cnt (cnt[r])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         stall_cnt_o <= '0;
    else if (stall_o) stall_cnt_o <= stall_cnt_o + 32'd1;
  end

  // Writeback must never retire a register with nothing in flight.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    (retire_i && (retire_addr_i != '0)) |-> (cnt[retire_addr_i] != '0));

endmodule

// File: tb/tb_idu_scoreboard.sv
module tb_idu_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_pre_i = 0, ready_post_i = 0;
  logic        rena1_i = 0, rena2_i = 0, wena_i = 0, retire_i = 0;
  logic [4:0]  raddr1_i = 0, raddr2_i = 0, waddr_i = 0, retire_addr_i = 0;
  logic        ready_pre_o, valid_post_o, stall_o, busy_o;
  logic [31:0] stall_cnt_o;

  idu_scoreboard dut (
    .clk(clk), .rst(rst),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .rena1_i(rena1_i), .raddr1_i(raddr1_i),
    .rena2_i(rena2_i), .raddr2_i(raddr2_i),
    .wena_i(wena_i), .waddr_i(waddr_i),
    .retire_i(retire_i), .retire_addr_i(retire_addr_i),
    .stall_o(stall_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, vpost, rpre, busy;
    logic [31:0] scnt;
  } exp_t;

  exp_t        q[$];
  logic [1:0]  m_cnt [32];
  logic [31:0] m_scnt;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    foreach (m_cnt[i]) m_cnt[i] = 2'd0;
    m_scnt = 0;
  endtask

  // One cycle: drive at posedge+1, push the model's prediction, pop and
  // compare at negedge, then advance the model on the posedge.
  task automatic cyc(input logic vp, input logic rp,
                     input logic e1, input logic [4:0] a1,
                     input logic e2, input logic [4:0] a2,
                     input logic we, input logic [4:0] wa,
                     input logic rt, input logic [4:0] ra);
    exp_t e;
    logic hz, iss, inc, dec;
    valid_pre_i = vp; ready_post_i = rp;
    rena1_i = e1; raddr1_i = a1; rena2_i = e2; raddr2_i = a2;
    wena_i = we; waddr_i = wa; retire_i = rt; retire_addr_i = ra;
    hz = (e1 && a1 != 0 && m_cnt[a1] != 0) || (e2 && a2 != 0 && m_cnt[a2] != 0)
      || (we && wa != 0 && m_cnt[wa] == 2'd3);
    e.stall = vp && hz;
    e.vpost = vp && !hz;
    e.rpre  = rp && !(vp && hz);
    e.busy  = 1'b0;
    foreach (m_cnt[i]) if (m_cnt[i] != 0) e.busy = 1'b1;
    e.scnt  = m_scnt;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk("stall_o", {31'd0, stall_o}, {31'd0, e.stall});
    chk("valid_post_o", {31'd0, valid_post_o}, {31'd0, e.vpost});
    chk("ready_pre_o", {31'd0, ready_pre_o}, {31'd0, e.rpre});
    chk("busy_o", {31'd0, busy_o}, {31'd0, e.busy});
    chk("stall_cnt_o", stall_cnt_o, e.scnt);
    @(posedge clk);
    iss = vp && e.rpre;
    if (e.stall) m_scnt = m_scnt + 1;
    inc = iss && we && wa != 0;
    dec = rt && ra != 0;
    if (!(inc && dec && wa == ra)) begin
      if (inc) m_cnt[wa] = m_cnt[wa] + 2'd1;
      if (dec && m_cnt[ra] != 0) m_cnt[ra] = m_cnt[ra] - 2'd1;
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_reset();
    #3;
    chk("rst busy_o", {31'd0, busy_o}, 32'd0);
    chk("rst stall_cnt_o", stall_cnt_o, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    idle();

    // dependent pair on x5, released one cycle after retire
    cyc(1, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 5, 0, 0, 0, 0, 1, 5);
    cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    chk("dep cnt5", {30'd0, dut.cnt[5]}, 32'd0);
    chk("dep stall_cnt", stall_cnt_o, 32'd2);

    // x0 never tracked, retire of x0 ignored
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
    chk("x0 busy", {31'd0, busy_o}, 32'd0);

    // simultaneous issue+retire of x7 nets to zero
    cyc(1, 1, 0, 0, 0, 0, 1, 7, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 7, 1, 7);
    chk("x7 net", {30'd0, dut.cnt[7]}, 32'd1);
    cyc(1, 1, 0, 0, 1, 7, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 7, 0, 0, 1, 7);
    cyc(1, 1, 0, 0, 1, 7, 0, 0, 0, 0);

    // saturation on x9
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 1, 9, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 9, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 9, 1, 9);
    cyc(1, 1, 0, 0, 0, 0, 1, 9, 0, 0);
    chk("sat cnt9", {30'd0, dut.cnt[9]}, 32'd3);

    // downstream backpressure, no hazard
    cyc(1, 0, 0, 0, 0, 0, 1, 10, 0, 0);
    chk("bp cnt10", {30'd0, dut.cnt[10]}, 32'd0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 9);
    chk("drain busy", {31'd0, busy_o}, 32'd0);

    // random traffic on x0..x7; retires only target busy registers
    for (int n = 0; n < 80; n++) begin
      logic [4:0] ra;
      logic       rt;
      int         pick;
      rt = 0; ra = 0;
      pick = $urandom_range(7, 1);
      if ($urandom_range(1, 0) == 1 && m_cnt[pick] != 0) begin
        rt = 1; ra = 5'(pick);
      end
      cyc(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) != 0),
          1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)),
          1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)),
          1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), rt, ra);
    end

    // async reset mid-operation
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    m_reset();
    cyc(1, 1, 0, 0, 0, 0, 1, 3, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 3, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 4, 0, 0);
    repeat (17) cyc(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    valid_pre_i = 1; rena1_i = 1; raddr1_i = 3;
    chk("pre cnt3", {30'd0, dut.cnt[3]}, 32'd2);
    chk("pre cnt4", {30'd0, dut.cnt[4]}, 32'd1);
    chk("pre stall_cnt", stall_cnt_o, 32'd17);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("arst cnt3", {30'd0, dut.cnt[3]}, 32'd0);
    chk("arst cnt4", {30'd0, dut.cnt[4]}, 32'd0);
    chk("arst busy_o", {31'd0, busy_o}, 32'd0);
    chk("arst stall_cnt", stall_cnt_o, 32'd0);
    chk("arst stall_o", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    m_reset();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/idu_scoreboard.md
Name: idu_scoreboard

Overview:
- Hazard controller that sits between the decode stage and the execute stage.
- Tracks in-flight register writes with per-register pending counters.
- Blocks the decode-to-execute handshake while a read-after-write hazard exists, or while the destination counter is saturated.
- Clears pending state as writeback retires writes to the register file.

Parameters:
NR_REGS, 32, number of architectural registers; x0 is never tracked
ADDR_W, 5, register address width (log2 NR_REGS)
CNT_W, 2, pending-write counter width per register; max outstanding writes per register = 2^CNT_W-1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
valid_pre_i  in  1  decode has a decoded instruction
ready_pre_o  out  1  scoreboard/execute accepts it
valid_post_o  out  1  instruction forwarded to execute
ready_post_i  in  1  execute can accept
rena1_i  in  1  rs1 read enable from decode
raddr1_i  in  ADDR_W  rs1 address
rena2_i  in  1  rs2 read enable
raddr2_i  in  ADDR_W  rs2 address
wena_i  in  1  decoded instruction writes rd
waddr_i  in  ADDR_W  rd address
retire_i  in  1  writeback commits a register write this cycle
retire_addr_i  in  ADDR_W  register being committed
stall_o  out  1  hazard present (combinational)
busy_o  out  1  at least one counter non-zero (registered-state derived)
stall_cnt_o  out  32  cycles with valid_pre_i=1 and stall_o=1

Behaviour:
- Reset (rst=0, async): all counters = 0, stall_cnt_o = 0, busy_o = 0. Outputs then follow the combinational rules below.
- Hazard terms:
  - raw1 = rena1_i & raddr1_i!=0 & cnt[raddr1_i]!=0
  - raw2 = rena2_i & raddr2_i!=0 & cnt[raddr2_i]!=0
  - sat = wena_i & waddr_i!=0 & cnt[waddr_i]==MAX
- stall_o = valid_pre_i & (raw1 | raw2 | sat).
- Handshake gating, combinational, zero added latency:
  - valid_post_o = valid_pre_i & ~stall_o
  - ready_pre_o = ready_post_i & ~stall_o
- An instruction issues in a cycle when valid_pre_i & ready_pre_o (implies valid_post_o & ready_post_i).
- Issue increment: on issue with wena_i=1 and waddr_i!=0, cnt[waddr_i] += 1 at the next clock edge.
- Retire decrement: retire_i=1 with retire_addr_i!=0 gives cnt[retire_addr_i] -= 1.
- Same register, same cycle, issue and retire: counter unchanged (net 0).
- Different registers, same cycle: both updates apply.
- Retiring x0 is ignored. Issuing with waddr_i=0 is not tracked.
- Retire on a counter already at 0: counter stays 0 (no underflow). This is a protocol error; assert in simulation.
- Saturated counter: further issue is blocked by sat, so the counter never wraps.
- Retire does not bypass the hazard check. A source whose counter is decremented this cycle still stalls this cycle; it is released next cycle (one-cycle retire-to-issue latency).
- Stall without upstream valid (valid_pre_i=0): stall_o=0.
- Handshake stability: the upstream must hold the instruction fields stable while valid_pre_i=1 and not accepted.
- stall_cnt_o:
  - Increments by 1 each cycle valid_pre_i & stall_o.
  - Wraps at 2^32.
  - Cleared only by reset.
- busy_o = OR of all counters != 0, computed from the current registered state.
- Reset mid-operation: all pending state is discarded immediately. The pipeline around the block is reset by the same signal.

Test Plan:
- Back-to-back dependent pair:
  - Issue wena_i=1 waddr_i=5, then the next instr with rena1_i=1 raddr1_i=5 → stall_o=1, ready_pre_o=0, valid_post_o=0.
  - Assert retire_i=1 retire_addr_i=5 → stall persists that cycle, deasserts the following cycle.
  - cnt[5] returns to 0; stall_cnt_o equals the number of stalled cycles.
- x0 handling: issue writing x0, then a read of x0 via rs1/rs2 → never stalls; busy_o stays 0.
- Simultaneous issue and retire of x7 with cnt[7]=1 → cnt[7] stays 1. A subsequent rs2=x7 read stalls until one more retire of x7.
- Saturation (CNT_W=2):
  - Issue 3 writes to x9 without retire → 4th write to x9 stalls (sat).
  - One retire of x9 → the 4th issues the next cycle; cnt ends at 3.
- Downstream backpressure: ready_post_i=0 with no hazard → ready_pre_o=0, valid_post_o=1, no counter change, stall_cnt_o unchanged.
- Async reset with cnt[3]=2, cnt[4]=1 and stall_cnt_o=17: drop rst low mid-cycle → all counters 0, busy_o=0, stall_cnt_o=0 immediately, without waiting for a clock edge.
